fetch_unit: RTL and testbench

//  Instruction-fetch stage that drives the synchronous-read instruction memory (inst_mem).
//  It sits between that memory and decode. Owns the PC and absorbs the 1-cycle memory read latency.

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 76 +++++++
 rtl/fetch_unit.sv | 117 +++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, state encoding and buffer entry type for the fetch stage.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          IMEM_AW          = 12;
    localparam int          BUF_DEPTH        = 2;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    // Word address presented to inst_mem for a byte PC.
    function automatic logic [31:0] word_addr(input logic [31:0] byte_pc);
        return {2'b00, byte_pc[31:2]};
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// fetch_skid_buf: two-entry FIFO of fetched {pc, instr} pairs sitting between the
// memory response and decode. Flush wins over a simultaneous push; no bypass path.
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  fetch_entry_t pushData_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [1:0]   count_o,
    output fetch_entry_t head_o
);

    fetch_entry_t entry_q [BUF_DEPTH];
    logic         rdPtr_q, rdPtr_d;
    logic         wrPtr_q, wrPtr_d;
    logic [1:0]   count_q, count_d;
    logic         doPush;
    logic         doPop;

    assign doPush  = push_i & ~flush_i;
    assign doPop   = pop_i & ~flush_i & (count_q != 2'd0);
    assign count_o = count_q;
    assign head_o  = entry_q[rdPtr_q];

    // Next pointer and occupancy values; a flush empties the buffer outright
    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (flush_i) begin
            rdPtr_d = 1'b0;
            wrPtr_d = 1'b0;
            count_d = 2'd0;
        end else begin
            if (doPush) begin
                wrPtr_d = ~wrPtr_q;
            end
            if (doPop) begin
                rdPtr_d = ~rdPtr_q;
            end
            count_d = count_q + {1'b0, doPush} - {1'b0, doPop};
        end
    end

    // Register pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdPtr_q <= 1'b0;
            wrPtr_q <= 1'b0;
            count_q <= 2'd0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; cleared on reset so the head reads as zero while empty after reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (doPush) begin
            entry_q[wrPtr_q] <= pushData_i;
        end
    end

    // Issue throttling upstream must never let a response arrive into a full buffer
    a_noOverflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(doPush && !doPop && (count_q == 2'(BUF_DEPTH))));

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, drives the synchronous-read instruction memory, absorbs its
// one-cycle latency and hands {pc, instr} to decode over valid/ready at one per cycle.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_dout,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  respPc_q, respPc_d;
    logic         respVld_q, respVld_d;
    logic         issueEn;
    logic         popEn;
    logic [2:0]   projected;
    logic [1:0]   bufCount;
    fetch_entry_t bufHead;
    fetch_entry_t pushEntry;

    assign popEn     = out_valid & out_ready;
    assign imem_addr = word_addr(pc_q);
    assign out_valid = (bufCount != 2'd0);
    assign out_pc    = bufHead.pc;
    assign out_instr = bufHead.instr;

    assign pushEntry.pc    = respPc_q;
    assign pushEntry.instr = imem_dout;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a redirect always lands in RUN, halt still gates issue there
    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = RUN;
        end else begin
            case (state_q)
                BOOT:    state_d = RUN;
                RUN:     if (halt) state_d = HALTED;
                HALTED:  if (!halt) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // Issue decision: only fetch when the buffer is guaranteed room for the response
    always_comb begin
        projected = {1'b0, bufCount} + {2'b00, respVld_q} - {2'b00, popEn};
        issueEn   = 1'b0;
        if ((state_q == RUN) && !halt && !redirect_valid && (projected < 3'(BUF_DEPTH))) begin
            issueEn = 1'b1;
        end
    end

    // PC and in-flight response tracking; a redirect drops whatever is in flight
    always_comb begin
        pc_d      = pc_q;
        respPc_d  = respPc_q;
        respVld_d = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~32'h3;
        end else if (issueEn) begin
            pc_d      = pc_q + 32'd4;
            respPc_d  = pc_q;
            respVld_d = 1'b1;
        end
    end

    // Register PC and response tracking
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            respPc_q  <= 32'h0;
            respVld_q <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            respPc_q  <= respPc_d;
            respVld_q <= respVld_d;
        end
    end

    fetch_skid_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_i     (respVld_q),
        .pushData_i (pushEntry),
        .pop_i      (popEn),
        .flush_i    (redirect_valid),
        .count_o    (bufCount),
        .head_o     (bufHead)
    );

    // A stalled entry must stay put until decode takes it
    a_stallStable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !redirect_valid) |=>
            (out_valid && $stable(out_pc) && $stable(out_instr)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: scoreboard bench for fetch_unit with a 1-cycle synchronous ROM model
// (mem[i] = A000_0000 + i); a second instance starts near the top of the address space.
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] MAIN_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] WRAP_RESET_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rstN;
    logic [31:0] imemAddr, imemDout;
    logic        redirectValid;
    logic [31:0] redirectPc;
    logic        halt;
    logic        outValid, outReady;
    logic [31:0] outInstr, outPc;

    logic [31:0] wrapAddr, wrapDout;
    logic        wrapRedirect = 1'b0;
    logic [31:0] wrapRedirectPc = 32'h0;
    logic        wrapHalt = 1'b0;
    logic        wrapValid;
    logic        wrapReady = 1'b1;
    logic [31:0] wrapInstr, wrapPc;

    int compared = 0;
    int mismatched = 0;

    fetch_entry_t expQ[$];
    fetch_entry_t wrapQ[$];
    fetch_entry_t monEntry, wrapEntry, fillEntry, seedEntry;
    logic [31:0]  nextPc;
    logic [31:0]  snapPc, snapAddr;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(MAIN_RESET_PC)) dut (
        .clk            (clk),
        .rst_n          (rstN),
        .imem_addr      (imemAddr),
        .imem_dout      (imemDout),
        .redirect_valid (redirectValid),
        .redirect_pc    (redirectPc),
        .halt           (halt),
        .out_valid      (outValid),
        .out_ready      (outReady),
        .out_instr      (outInstr),
        .out_pc         (outPc)
    );

    fetch_unit #(.RESET_PC(WRAP_RESET_PC)) dutWrap (
        .clk            (clk),
        .rst_n          (rstN),
        .imem_addr      (wrapAddr),
        .imem_dout      (wrapDout),
        .redirect_valid (wrapRedirect),
        .redirect_pc    (wrapRedirectPc),
        .halt           (wrapHalt),
        .out_valid      (wrapValid),
        .out_ready      (wrapReady),
        .out_instr      (wrapInstr),
        .out_pc         (wrapPc)
    );

    // ROM contents as a function of the word address; only the low IMEM_AW bits decode
    function automatic logic [31:0] romWord(input logic [31:0] wordAddr);
        logic [31:0] mask;
        mask = (32'd1 << IMEM_AW) - 32'd1;
        return 32'hA000_0000 + (wordAddr & mask);
    endfunction

    // One-cycle synchronous ROMs feeding the two instances
    always @(posedge clk) begin
        imemDout <= romWord(imemAddr);
        wrapDout <= romWord(wrapAddr);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs and advance to just after the next rising edge
    task automatic applyStimulus(input logic rdy, input logic hlt, input logic rv, input logic [31:0] rpc);
        outReady      = rdy;
        halt          = hlt;
        redirectValid = rv;
        redirectPc    = rpc;
        @(posedge clk);
        #1;
    endtask

    // Main scoreboard: pop/compare on each handshake, restart the expected stream on reset/redirect
    always @(negedge clk) begin
        if (!rstN) begin
            expQ.delete();
            nextPc = MAIN_RESET_PC;
        end else begin
            if (outValid && outReady) begin
                monEntry = expQ.pop_front();
                checkOutput("outPc", outPc, monEntry.pc);
                checkOutput("outInstr", outInstr, monEntry.instr);
            end
            if (redirectValid) begin
                expQ.delete();
                nextPc = redirectPc & ~32'h3;
            end
        end
        while (expQ.size() < 8) begin
            fillEntry.pc    = nextPc;
            fillEntry.instr = romWord({2'b00, nextPc[31:2]});
            expQ.push_back(fillEntry);
            nextPc = nextPc + 32'd4;
        end
    end

    // Wrap-instance scoreboard: checks the first outputs after reset release
    always @(negedge clk) begin
        if (rstN && wrapValid && (wrapQ.size() != 0)) begin
            wrapEntry = wrapQ.pop_front();
            checkOutput("wrapPc", wrapPc, wrapEntry.pc);
            checkOutput("wrapInstr", wrapInstr, wrapEntry.instr);
        end
    end

    initial begin
        rstN          = 1'b0;
        outReady      = 1'b1;
        halt          = 1'b0;
        redirectValid = 1'b0;
        redirectPc    = 32'h0;

        seedEntry.pc = 32'hFFFF_FFF8; seedEntry.instr = 32'hA000_0FFE; wrapQ.push_back(seedEntry);
        seedEntry.pc = 32'hFFFF_FFFC; seedEntry.instr = 32'hA000_0FFF; wrapQ.push_back(seedEntry);
        seedEntry.pc = 32'h0000_0000; seedEntry.instr = 32'hA000_0000; wrapQ.push_back(seedEntry);
        seedEntry.pc = 32'h0000_0004; seedEntry.instr = 32'hA000_0001; wrapQ.push_back(seedEntry);

        // Reset state
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("rstValid", {31'h0, outValid}, 32'h0);
        checkOutput("rstPc", outPc, 32'h0);
        checkOutput("rstInstr", outInstr, 32'h0);
        checkOutput("rstAddr", imemAddr, MAIN_RESET_PC >> 2);

        // Release: first out_valid in cycle 3, then no gaps
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("bootValid", {31'h0, outValid}, {31'h0, k == 3});
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            checkOutput("streamValid", {31'h0, outValid}, 32'h1);
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        end

        // Stall for 5 cycles: head and fetch address frozen
        snapPc   = expQ[0].pc;
        snapAddr = (snapPc + 32'd8) >> 2;
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
            checkOutput("stallValid", {31'h0, outValid}, 32'h1);
            checkOutput("stallPc", outPc, snapPc);
            checkOutput("stallAddr", imemAddr, snapAddr);
        end
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("releaseValid", {31'h0, outValid}, 32'h1);
        end

        // Redirect to 0x100 while the buffer is full
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h0000_0100);
        checkOutput("redirValid1", {31'h0, outValid}, 32'h0);
        checkOutput("redirAddr", imemAddr, 32'h0000_0040);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redirValid2", {31'h0, outValid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("redirValid3", {31'h0, outValid}, 32'h1);
        checkOutput("redirPc", outPc, 32'h0000_0100);
        checkOutput("redirInstr", outInstr, 32'hA000_0040);

        // Misaligned redirect in the same cycle as a pop
        for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("popRedirValid", {31'h0, outValid}, 32'h1);
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_0203);
        checkOutput("popRedirValid1", {31'h0, outValid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("popRedirValid2", {31'h0, outValid}, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("popRedirValid3", {31'h0, outValid}, 32'h1);
        checkOutput("popRedirPc", outPc, 32'h0000_0200);
        checkOutput("popRedirInstr", outInstr, 32'hA000_0080);

        // Halt for 4 cycles: drain, then resume at the next sequential pc
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        snapAddr = (expQ[0].pc + 32'd8) >> 2;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
            checkOutput("haltValid", {31'h0, outValid}, {31'h0, k == 0});
            checkOutput("haltAddr", imemAddr, snapAddr);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
            checkOutput("resumeValid", {31'h0, outValid}, {31'h0, k == 2});
        end
        checkOutput("resumePc", outPc, snapAddr << 2);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        // Reset mid-stream
        rstN = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        checkOutput("midRstValid", {31'h0, outValid}, 32'h0);
        checkOutput("midRstAddr", imemAddr, MAIN_RESET_PC >> 2);
        rstN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            checkOutput("rebootValid", {31'h0, outValid}, {31'h0, k == 3});
            applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
        end
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);

        checkOutput("wrapSeen", 32'(wrapQ.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
